// File: rtl/mips_regs_pkg.sv
// Shared constants for the MIPS general-purpose register file and the
// RegDst destination-select encodings that feed its write index.
package mips_regs_pkg;

    localparam int           WIDTH    = 32;
    localparam logic [4:0]   REG_ZERO = 5'd0;
    localparam logic [4:0]   REG_SP   = 5'd29;
    localparam logic [4:0]   REG_RA   = 5'd31;
    localparam logic [31:0]  SP_RESET = 32'd227;

    typedef enum logic [2:0] {
        REGDST_RT = 3'b000,
        REGDST_RD = 3'b001,
        REGDST_RA = 3'b010,
        REGDST_SP = 3'b011,
        REGDST_RS = 3'b100
    } regdst_e;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: $zero masking, same-cycle
// write bypass, then selection from the stored array.
module reg_read_port
    import mips_regs_pkg::*;
#(
    parameter int WIDTH = mips_regs_pkg::WIDTH
) (
    input  logic [4:0]             rd_idx_i,
    input  logic [31:0][WIDTH-1:0] regs_i,
    input  logic                   wr_en_i,
    input  logic [4:0]             wr_idx_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o
);

    // Zero check first, then bypass of the in-flight write, then storage
    always_comb begin
        rd_data_o = {WIDTH{1'b0}};
        if (rd_idx_i == REG_ZERO) begin
            rd_data_o = {WIDTH{1'b0}};
        end else if (wr_en_i && (rd_idx_i == wr_idx_i)) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = regs_i[rd_idx_i];
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// 32 x WIDTH MIPS register file at the write-back end of the RegDst path,
// with two bypassed read ports, a raw debug port and write statistics.
module reg_bank_wb
    import mips_regs_pkg::*;
#(
    parameter int          WIDTH    = mips_regs_pkg::WIDTH,
    parameter logic [31:0] SP_RESET = mips_regs_pkg::SP_RESET,
    parameter logic [4:0]  REG_SP   = mips_regs_pkg::REG_SP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       read_reg1,
    input  logic [4:0]       read_reg2,
    input  logic [4:0]       dbg_reg,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    output logic [WIDTH-1:0] dbg_data,
    output logic [4:0]       last_wr_reg,
    output logic [15:0]      wr_count
);

    logic [31:0][WIDTH-1:0] regs_q;
    logic [4:0]             last_wr_q;
    logic [15:0]            wr_count_q;
    logic [15:0]            wr_count_d;
    logic                   wr_en_s;

    // A RegWrite of 0 masks an unknown write_reg so it cannot reach state
    assign wr_en_s = RegWrite && (write_reg != REG_ZERO);

    // Write counter wraps naturally at 16 bits
    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en_s) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Register array and write statistics; reset restores $sp only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (5'(i) == REG_SP) ? WIDTH'(SP_RESET) : {WIDTH{1'b0}};
            end
            last_wr_q  <= 5'd0;
            wr_count_q <= 16'd0;
        end else if (wr_en_s) begin
            regs_q[write_reg] <= write_data;
            last_wr_q         <= write_reg;
            wr_count_q        <= wr_count_d;
        end else begin
            last_wr_q  <= last_wr_q;
            wr_count_q <= wr_count_q;
        end
    end

    reg_read_port #(.WIDTH(WIDTH)) u_port_rs (
        .rd_idx_i  (read_reg1),
        .regs_i    (regs_q),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (write_reg),
        .wr_data_i (write_data),
        .rd_data_o (read_data1)
    );

    reg_read_port #(.WIDTH(WIDTH)) u_port_rt (
        .rd_idx_i  (read_reg2),
        .regs_i    (regs_q),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (write_reg),
        .wr_data_i (write_data),
        .rd_data_o (read_data2)
    );

    // Index 0 is never written, so the raw select already yields zero there
    assign dbg_data    = regs_q[dbg_reg];
    assign last_wr_reg = last_wr_q;
    assign wr_count    = wr_count_q;

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file; write-back end of the register-destination path.
- Consumes the 5-bit destination index chosen by the RegDst selection (rt, rd, $ra=31, $sp=29, rs) plus write-back data.
- Provides two combinational read ports (rs, rt) to the datapath and one debug read port.
- Read-during-write bypass gives same-cycle visibility of the value being written.

Parameters:
- WIDTH, 32, register data width in bits
- SP_RESET, 32'd227, reset value of $sp (register 29)
- REG_SP, 5'd29, stack pointer index
- REG_RA, 5'd31, return address index

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- RegWrite  input  1  write enable for the current cycle
- write_reg  input  5  destination index (output of the RegDst selection)
- write_data  input  WIDTH  write-back data
- read_reg1  input  5  rs index
- read_reg2  input  5  rt index
- dbg_reg  input  5  debug/inspection index
- read_data1  output  WIDTH  value of read_reg1
- read_data2  output  WIDTH  value of read_reg2
- dbg_data  output  WIDTH  value of dbg_reg (no bypass)
- last_wr_reg  output  5  index of the last committed non-zero write
- wr_count  output  16  number of committed non-zero writes since reset

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately regardless of clk):
  - all registers become 0, except reg[REG_SP] = SP_RESET
  - last_wr_reg = 0; wr_count = 0
  - read outputs reflect the reset contents combinationally
- Write: on posedge clk with reset_n=1, RegWrite=1 and write_reg != 0:
  - reg[write_reg] <= write_data
  - last_wr_reg <= write_reg
  - wr_count <= wr_count + 1, wrapping from 16'hFFFF to 0
- Writes to index 0 are discarded:
  - no state change, wr_count does not increment
  - reg[0] reads as 0 always
- RegWrite=0: no state change.
- Read ports 1/2 are combinational, zero latency:
  - index 0 -> 0
  - else if RegWrite=1 and index == write_reg (and write_reg != 0) -> write_data (bypass)
  - else -> reg[index]
- Both read ports may address the same register, including the one being written; both return the bypassed value.
- dbg_data is combinational from stored contents only (no bypass): it shows the new value starting the cycle after the write edge.
- Reset asserted mid-cycle while RegWrite=1: the reset wins and the write is lost; no partial update.
- Reset released: the first rising edge with reset_n=1 may perform a write.
- No X propagation: unknown write_reg while RegWrite=0 must not corrupt state.

Decomposition:
- Shared package (mips_regs_pkg):
  - register index constants: REG_ZERO=0, REG_SP=29, REG_RA=31
  - SP_RESET value
  - WIDTH
  - RegDst encodings: 000 rt, 001 rd, 010 ra, 011 sp, 100 rs
- One natural sub-module, reg_read_port:
  - combinational zero-check, bypass compare and array select
  - instantiated twice for rs/rt; the debug port uses the array select only

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> immediately read_data1 (read_reg1=29) = 227, read_data2 (read_reg2=5) = 0, wr_count=0.
- Write/read: RegWrite=1, write_reg=8, write_data=32'hDEADBEEF at edge.
  - Next cycle read_reg1=8 -> 32'hDEADBEEF
  - last_wr_reg=8, wr_count=1
- $zero protection: write_reg=0, write_data=32'h12345678, RegWrite=1 -> read_reg1=0 reads 0 before and after the edge; wr_count unchanged.
- Bypass: RegWrite=1, write_reg=31, write_data=32'h00400010, read_reg1=read_reg2=31 in the same cycle.
  - Both outputs = 32'h00400010 before the edge
  - dbg_data (dbg_reg=31) shows the old value until after the edge
- Reset vs write: write reg 29 = 32'h1000 during cycle, drop reset_n before the edge -> reg29 = 227, wr_count=0 after release.
- Counter wrap: 65536 writes to reg 3 -> wr_count returns to 0, reg 3 holds the last written data.
